// File: rtl/scalar_mem_pkg.sv
// ---------------------------------------------------------------------------
// scalar_mem_pkg
//
// Shared definitions for the wait-state memory of the scalar processor
// family: the handshake FSM state encoding, the default data/address
// widths, and a helper that sizes the wait counter for a given number of
// wait states.
//
// Contents:
//   state_e       two-state FSM encoding (IDLE, ACCESS)
//   DATA_W_DEF    default data word width
//   ADDR_W_DEF    default address width
//   cnt_width()   minimum counter width able to hold 0..wait_cycles
// ---------------------------------------------------------------------------
package scalar_mem_pkg;

    // IDLE waits for a request; ACCESS counts out the wait states and
    // completes the access on the last one.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    // Counter width needed to count from 0 up to wait_cycles inclusive.
    // A zero-wait configuration still gets a one-bit counter so the
    // counter vector never collapses to zero width.
    function automatic int cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/scalar_sp_ram.sv
// ---------------------------------------------------------------------------
// scalar_sp_ram
//
// Single-port synchronous word array. Writes land on the rising edge when
// we is high; dout is registered and always shows the word at addr as
// seen at the previous rising edge (read-first on a simultaneous write).
// There is deliberately no reset: contents survive a controller reset.
//
// Ports:
//   clk   in   system clock
//   we    in   write enable
//   addr  in   word address (ADDR_W bits)
//   din   in   write data (DATA_W bits)
//   dout  out  registered read data (DATA_W bits)
// ---------------------------------------------------------------------------
module scalar_sp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q;

    // Array write and registered read share the one address port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout_q <= mem_q[addr];
    end

    assign dout = dout_q;

endmodule

// File: rtl/scalar_wait_mem.sv
// ---------------------------------------------------------------------------
// scalar_wait_mem
//
// Program/data memory for the scalar processor with a request/ready
// handshake and a fixed number of wait states. A read or write request is
// sampled while idle, its address, data and direction are captured, and
// the access completes WAIT_CYCLES+1 edges later with a one-cycle ready
// pulse. A request with rd and wrt both high is refused with a one-cycle
// err pulse. The storage itself lives in scalar_sp_ram.
//
// Ports:
//   clk    in   system clock, all state changes on the rising edge
//   rst    in   synchronous active-low reset
//   add    in   request address (ADDR_W bits)
//   rd     in   read request, sampled while idle
//   wrt    in   write request, sampled while idle
//   wdata  in   write data, captured with the request (DATA_W bits)
//   rdata  out  last completed read value (DATA_W bits)
//   ready  out  one-cycle pulse on access completion
//   busy   out  high while an accepted access is pending
//   err    out  one-cycle pulse when rd and wrt were requested together
// ---------------------------------------------------------------------------
module scalar_wait_mem
    import scalar_mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] add,
    input  logic              rd,
    input  logic              wrt,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              access_done;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    // Next-state logic. Everything holds by default; ready and err are
    // pulses and so default low. In IDLE exactly one of rd/wrt starts an
    // access, both together raise err. In ACCESS the counter runs up to
    // WAIT_LAST and the final edge completes the access, returning to IDLE
    // so a new request can be sampled during the ready cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;
        access_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd ^ wrt) begin
                    addr_d  = add;
                    wdata_d = wdata;
                    is_wr_d = wrt;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACCESS;
                end else if (rd & wrt) begin
                    err_d = 1'b1;
                end
            end

            ACCESS: begin
                if (cnt_q == WAIT_LAST) begin
                    access_done = 1'b1;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                    if (!is_wr_q) begin
                        rdata_d = ram_dout;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any pending access and
    // clears the captured request, but leaves the array untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // The RAM address follows addr_d so its registered output already
    // holds the requested word one edge after the request is accepted,
    // which lets a zero-wait read complete on the very next edge. During
    // ACCESS addr_d equals the captured address, so input changes while
    // busy cannot reach the array. The write is gated by rst so a reset
    // landing on the completion edge still drops the write.
    assign ram_we = access_done & is_wr_q & rst;

    scalar_sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr_d),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_scalar_wait_mem.sv
// ---------------------------------------------------------------------------
// tb_scalar_wait_mem
//
// Drives four copies of scalar_wait_mem, configured with WAIT_CYCLES of
// 0, 1, 2 and 3, from one shared set of request inputs. Instance i has
// WAIT_CYCLES == i, so a request sampled at one edge is completed by each
// copy with its own latency, and all copies hold identical memory
// contents. Expected values are hand-computed directed vectors.
// ---------------------------------------------------------------------------
module tb_scalar_wait_mem;

    logic       clk;
    logic       rst;
    logic [7:0] add;
    logic       rd;
    logic       wrt;
    logic [7:0] wdata;

    logic [7:0] rdata_v [4];
    logic [3:0] ready_v;
    logic [3:0] busy_v;
    logic [3:0] err_v;

    int checkCount;
    int errorCount;

    int readyAt  [4];
    int readyCnt [4];
    int busyCnt  [4];
    int errAt    [4];
    int errCnt   [4];
    int bothCnt  [4];

    scalar_wait_mem #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .add(add), .rd(rd), .wrt(wrt), .wdata(wdata),
        .rdata(rdata_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .err(err_v[0])
    );
    scalar_wait_mem #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .add(add), .rd(rd), .wrt(wrt), .wdata(wdata),
        .rdata(rdata_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .err(err_v[1])
    );
    scalar_wait_mem #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(2), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .add(add), .rd(rd), .wrt(wrt), .wdata(wdata),
        .rdata(rdata_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .err(err_v[2])
    );
    scalar_wait_mem #(.DATA_W(8), .ADDR_W(8), .WAIT_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .add(add), .rd(rd), .wrt(wrt), .wdata(wdata),
        .rdata(rdata_v[3]), .ready(ready_v[3]), .busy(busy_v[3]), .err(err_v[3])
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single point of comparison: counts every check and reports misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one request for a single sampling edge, then watch every
    // instance for eight cycles. Cycle j is the cycle after edge k+j where
    // k is the sampling edge. With disturb set, a different write request
    // is driven during the first busy cycle to show it is ignored.
    task automatic applyStimulus(input logic r, input logic w, input logic [7:0] a,
                                 input logic [7:0] d, input logic disturb);
        @(negedge clk);
        rd    = r;
        wrt   = w;
        add   = a;
        wdata = d;
        @(posedge clk);
        #1;
        if (disturb) begin
            rd    = 1'b0;
            wrt   = 1'b1;
            add   = 8'h21;
            wdata = 8'h22;
        end else begin
            rd  = 1'b0;
            wrt = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            readyAt[i]  = -1;
            readyCnt[i] = 0;
            busyCnt[i]  = 0;
            errAt[i]    = -1;
            errCnt[i]   = 0;
            bothCnt[i]  = 0;
        end
        for (int j = 0; j < 8; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
                rd  = 1'b0;
                wrt = 1'b0;
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ready_v[i]) begin
                    readyCnt[i]++;
                    if (readyAt[i] < 0) readyAt[i] = j;
                end
                if (busy_v[i]) busyCnt[i]++;
                if (err_v[i]) begin
                    errCnt[i]++;
                    if (errAt[i] < 0) errAt[i] = j;
                end
                if (ready_v[i] && err_v[i]) bothCnt[i]++;
            end
        end
    endtask

    // Instance i has WAIT_CYCLES == i: an accepted access is busy for
    // i+1 cycles and ready shows in cycle i+1. A refused request shows
    // err in cycle 0 and never goes busy or ready.
    task automatic checkTiming(input string tag, input logic accepted);
        for (int i = 0; i < 4; i++) begin
            if (accepted) begin
                checkOutput($sformatf("%s.w%0d.readyAt", tag, i), readyAt[i], i + 1);
                checkOutput($sformatf("%s.w%0d.readyCnt", tag, i), readyCnt[i], 1);
                checkOutput($sformatf("%s.w%0d.busyCnt", tag, i), busyCnt[i], i + 1);
                checkOutput($sformatf("%s.w%0d.errCnt", tag, i), errCnt[i], 0);
            end else begin
                checkOutput($sformatf("%s.w%0d.errAt", tag, i), errAt[i], 0);
                checkOutput($sformatf("%s.w%0d.errCnt", tag, i), errCnt[i], 1);
                checkOutput($sformatf("%s.w%0d.readyCnt", tag, i), readyCnt[i], 0);
                checkOutput($sformatf("%s.w%0d.busyCnt", tag, i), busyCnt[i], 0);
            end
            checkOutput($sformatf("%s.w%0d.readyAndErr", tag, i), bothCnt[i], 0);
        end
    endtask

    task automatic checkRdata(input string tag, input logic [7:0] expected);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s.w%0d.rdata", tag, i), rdata_v[i], expected);
        end
    endtask

    logic [7:0] bbAddr [5];
    logic [7:0] bbData [5];
    int         bbPos  [5];
    logic [7:0] bbGot  [5];
    int         bbSeen;
    int         lateReady;

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst   = 1'b0;
        rd    = 1'b0;
        wrt   = 1'b0;
        add   = 8'h00;
        wdata = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.flags", {ready_v, busy_v, err_v}, 12'h000);
        checkRdata("reset", 8'h00);
        rst = 1'b1;

        // Write then read back 0x80; rdata is unaffected by the write.
        applyStimulus(1'b0, 1'b1, 8'h80, 8'h45, 1'b0);
        checkTiming("wr80", 1'b1);
        checkRdata("wr80", 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h80, 8'h00, 1'b0);
        checkTiming("rd80", 1'b1);
        checkRdata("rd80", 8'h45);

        // Preloaded word read under every wait setting.
        applyStimulus(1'b0, 1'b1, 8'h91, 8'hA7, 1'b0);
        checkTiming("wr91", 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h91, 8'h00, 1'b0);
        checkTiming("rd91", 1'b1);
        checkRdata("rd91", 8'hA7);

        // Simultaneous rd and wrt is refused and changes nothing.
        applyStimulus(1'b0, 1'b1, 8'h10, 8'h66, 1'b0);
        checkTiming("wr10", 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h10, 8'hFF, 1'b0);
        checkTiming("both10", 1'b0);
        checkRdata("both10", 8'hA7);
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        checkTiming("rd10", 1'b1);
        checkRdata("rd10", 8'h66);

        // Request inputs changing while busy are ignored.
        applyStimulus(1'b0, 1'b1, 8'h21, 8'h5A, 1'b0);
        checkTiming("wr21", 1'b1);
        checkRdata("wr21", 8'h66);
        applyStimulus(1'b0, 1'b1, 8'h20, 8'h11, 1'b1);
        checkTiming("wr20busy", 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
        checkRdata("rd20", 8'h11);
        applyStimulus(1'b1, 1'b0, 8'h21, 8'h00, 1'b0);
        checkRdata("rd21", 8'h5A);

        // Reset in the first busy cycle aborts the write to 0xF0.
        applyStimulus(1'b0, 1'b1, 8'hF0, 8'h3C, 1'b0);
        checkTiming("wrF0", 1'b1);
        @(negedge clk);
        wrt   = 1'b1;
        add   = 8'hF0;
        wdata = 8'h01;
        @(posedge clk);
        #1;
        wrt = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort.busyBefore", busy_v, 4'hF);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort.flags", {ready_v, busy_v, err_v}, 12'h000);
        checkRdata("abort", 8'h00);
        rst = 1'b1;
        lateReady = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            lateReady += int'(ready_v[0]) + int'(ready_v[1]) + int'(ready_v[2]) + int'(ready_v[3]);
        end
        checkOutput("abort.noReady", lateReady, 0);
        applyStimulus(1'b1, 1'b0, 8'hF0, 8'h00, 1'b0);
        checkTiming("rdF0", 1'b1);
        checkRdata("rdF0", 8'h3C);

        // Back-to-back reads with rd held high, observed on the
        // WAIT_CYCLES=1 instance: samples at edges 0,3,6,9,12, ready in
        // the cycle after edges 2,5,8,11,14.
        bbAddr[0] = 8'h00; bbData[0] = 8'hA0;
        bbAddr[1] = 8'h01; bbData[1] = 8'hB1;
        bbAddr[2] = 8'h02; bbData[2] = 8'hC2;
        bbAddr[3] = 8'h03; bbData[3] = 8'hD3;
        bbAddr[4] = 8'hFF; bbData[4] = 8'hEF;
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b0, 1'b1, bbAddr[n], bbData[n], 1'b0);
        end
        @(negedge clk);
        rd     = 1'b1;
        add    = bbAddr[0];
        bbSeen = 0;
        for (int n = 0; n < 5; n++) begin
            bbPos[n] = -1;
            bbGot[n] = 8'h00;
        end
        for (int j = 0; j < 16; j++) begin
            @(posedge clk);
            #1;
            if (j % 3 == 0) begin
                if (j / 3 + 1 < 5) add = bbAddr[j / 3 + 1];
                else rd = 1'b0;
            end
            @(negedge clk);
            if (ready_v[1]) begin
                if (bbSeen < 5) begin
                    bbPos[bbSeen] = j;
                    bbGot[bbSeen] = rdata_v[1];
                end
                bbSeen++;
            end
        end
        checkOutput("b2b.count", bbSeen, 5);
        for (int n = 0; n < 5; n++) begin
            checkOutput($sformatf("b2b.pos%0d", n), bbPos[n], 3 * n + 2);
            checkOutput($sformatf("b2b.data%0d", n), bbGot[n], bbData[n]);
        end
        rd = 1'b0;
        repeat (8) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
